// File: rtl/ulpi_pkg.sv
// Shared ULPI link-side definitions: TXCMD codes, register address width
// and the register-write engine state encoding.
// Optional build macro: ULPI_EXT_ADDR_EN selects 8-bit register addresses
// with the extended-address TXCMD form.
package ulpi_pkg;

  // TXCMD command codes carried in data[7:6]
  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;

  // Address field value that redirects to the extended-address byte
  localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;

`ifdef ULPI_EXT_ADDR_EN
  localparam int REG_ADDR_W = 8;
`else
  localparam int REG_ADDR_W = 6;
`endif

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_TXCMD,
`ifdef ULPI_EXT_ADDR_EN
    WR_EXT_ADDR,
`endif
    WR_DATA,
    WR_STOP,
    WR_ERR
  } wr_state_e;

`ifdef ULPI_EXT_ADDR_EN
  // Addresses outside 0x00-0x3F, and 0x2F itself (which would collide with
  // the redirect code), must go through the extended-address byte.
  function automatic logic needs_ext_addr(input logic [7:0] addr);
    return (addr[7:6] != 2'b00) || (addr == {2'b00, EXT_ADDR_CODE});
  endfunction
`endif

endpackage

// File: rtl/ulpi_turnaround.sv
// Bus-direction tracker shared by the ULPI register engines. The link may
// drive ulpi_data only when dir is low now and was low last cycle, which
// excludes the turnaround cycle after the PHY releases the bus.
module ulpi_turnaround (
  input  logic clk,
  input  logic rst_n,
  input  logic ulpi_dir_i,
  output logic bus_owned_o,
  output logic dir_rise_o
);

  logic dir_q;

  // Register dir to detect turnaround and rising edges.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= ulpi_dir_i;
  end

  assign bus_owned_o = !ulpi_dir_i && !dir_q;
  assign dir_rise_o  = ulpi_dir_i && !dir_q;

endmodule

// File: rtl/ulpi_reg_write.sv
// ULPI register-write transaction engine (link side).
// Sequence: TXCMD RegWrite -> [extended address] -> data byte -> stp.
// PHY aborts (dir rising) restart from TXCMD up to RETRY_LIMIT times;
// NXT_TIMEOUT owned cycles without nxt ends the transfer with an error.
// Optional build macro: ULPI_EXT_ADDR_EN (8-bit addresses, EXT_ADDR phase).
module ulpi_reg_write
  import ulpi_pkg::*;
#(
  parameter int RETRY_LIMIT = 4,
  parameter int NXT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] reg_write_addr,
  input  logic [7:0]            reg_write_data,
  input  logic                  reg_write_en,
  input  logic                  ulpi_dir,
  input  logic                  ulpi_nxt,
  output logic [7:0]            ulpi_data_out,
  output logic                  ulpi_data_oe,
  output logic                  ulpi_stp,
  output logic                  reg_write_busy,
  output logic                  reg_write_done,
  output logic                  reg_write_err
);

  localparam int RETRY_W = $clog2(RETRY_LIMIT + 1);
  localparam int TMO_W   = $clog2(NXT_TIMEOUT + 1);

  wr_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [TMO_W-1:0]      timeout_q, timeout_d;

  logic bus_owned;
  logic dir_rise;

  ulpi_turnaround u_turnaround (
    .clk        (clk),
    .rst_n      (rst_n),
    .ulpi_dir_i (ulpi_dir),
    .bus_owned_o(bus_owned),
    .dir_rise_o (dir_rise)
  );

  // State, request latches and counters.
  // NOTE: the address/data latches are reset too; they are a handful of flops, not a memory, and a known value keeps the bus quiet after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WR_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      retry_q   <= '0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic and bus outputs, all decoded from state and bus direction.
  // NOTE: every signal gets a default first so no path leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    retry_d        = retry_q;
    timeout_d      = timeout_q;
    ulpi_data_out  = 8'h00;
    ulpi_data_oe   = 1'b0;
    ulpi_stp       = 1'b0;
    reg_write_busy = (state_q != WR_IDLE);
    reg_write_done = 1'b0;
    reg_write_err  = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (reg_write_en) begin
          addr_d    = reg_write_addr;
          data_d    = reg_write_data;
          retry_d   = '0;
          timeout_d = '0;
          state_d   = WR_TXCMD;
        end
      end

`ifdef ULPI_EXT_ADDR_EN
      WR_TXCMD, WR_EXT_ADDR, WR_DATA: begin
`else
      WR_TXCMD, WR_DATA: begin
`endif
        // Drive value for the current phase; suppressed when the PHY owns the bus
        if (bus_owned) begin
          ulpi_data_oe = 1'b1;
          case (state_q)
`ifdef ULPI_EXT_ADDR_EN
            WR_TXCMD:    ulpi_data_out = needs_ext_addr(addr_q) ?
                                         {TXCMD_REGW, EXT_ADDR_CODE} :
                                         {TXCMD_REGW, addr_q[5:0]};
            WR_EXT_ADDR: ulpi_data_out = addr_q;
`else
            WR_TXCMD:    ulpi_data_out = {TXCMD_REGW, addr_q[5:0]};
`endif
            default:     ulpi_data_out = data_q;
          endcase
        end

        if (dir_rise) begin
          // PHY took the bus: restart from TXCMD unless retries are used up
          timeout_d = '0;
          if (retry_q == RETRY_W'(RETRY_LIMIT)) begin
            state_d = WR_ERR;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = WR_TXCMD;
          end
        end else if (bus_owned) begin
          if (ulpi_nxt) begin
            timeout_d = '0;
            case (state_q)
`ifdef ULPI_EXT_ADDR_EN
              WR_TXCMD:    state_d = needs_ext_addr(addr_q) ? WR_EXT_ADDR : WR_DATA;
              WR_EXT_ADDR: state_d = WR_DATA;
`else
              WR_TXCMD:    state_d = WR_DATA;
`endif
              default:     state_d = WR_STOP;
            endcase
          end else if (timeout_q == TMO_W'(NXT_TIMEOUT - 1)) begin
            state_d = WR_ERR;
          end else begin
            timeout_d = timeout_q + TMO_W'(1);
          end
        end
      end

      WR_STOP: begin
        // Write already committed by nxt in DATA; dir here cannot undo it
        ulpi_stp       = 1'b1;
        ulpi_data_oe   = bus_owned;
        reg_write_done = 1'b1;
        state_d        = WR_IDLE;
      end

      WR_ERR: begin
        reg_write_done = 1'b1;
        reg_write_err  = 1'b1;
        state_d        = WR_IDLE;
      end

      default: state_d = WR_IDLE;
    endcase
  end

endmodule

// File: doc/ulpi_reg_write.md
Name: ulpi_reg_write

Overview:
- Link-side ULPI register-write transaction engine; runs alongside the register-read engine under the ULPI register controller, which holds its write address, data and enable.
- Takes one address/data request, issues TXCMD RegWrite, drives the data byte, then asserts stp.
- Outputs drive-side signals (data_out/oe/stp); the top level resolves the ulpi_data tristate and ORs stp with the read engine.

Parameters:
- RETRY_LIMIT, 4: PHY aborts (dir asserted mid-transaction) tolerated before failing.
- NXT_TIMEOUT, 255: consecutive owned-bus cycles waiting for nxt before failing; counter width $clog2(NXT_TIMEOUT+1).

Ports:
- clk  in  1  ULPI 60 MHz clock from PHY.
- rst_n  in  1  asynchronous, active-low reset.
- reg_write_addr  in  6 (8 with ULPI_EXT_ADDR_EN)  PHY register address.
- reg_write_data  in  8  byte to write.
- reg_write_en  in  1  level request; held by controller until done.
- ulpi_dir  in  1  PHY bus direction.
- ulpi_nxt  in  1  PHY throttle.
- ulpi_data_out  out  8  link drive value.
- ulpi_data_oe  out  1  link drives ulpi_data when 1.
- ulpi_stp  out  1  stop strobe.
- reg_write_busy  out  1  transaction in progress.
- reg_write_done  out  1  one-cycle completion pulse (success or failure).
- reg_write_err  out  1  high with done on failure.

Behaviour:
- Reset: state IDLE, counters 0, dir_q 0. All outputs 0 immediately on rst_n low, including mid-transaction; the bus is released at once.
- dir_q is ulpi_dir registered. Link owns the bus only when ulpi_dir==0 && dir_q==0 (turnaround cycle excluded).
- data_out, oe, stp, done and err are combinational from state, ulpi_dir and dir_q. oe is forced 0 whenever the link does not own the bus.
- IDLE: outputs 0, busy 0. On reg_write_en=1, latch addr/data, clear retry and timeout counters, and go to TXCMD.
- TXCMD: busy 1. When owned: oe=1, data_out={2'b10, addr[5:0]}. Timeout counter increments each owned cycle with nxt=0.
  - nxt=1 while owned: go to DATA.
  - Not owned: hold, and timeout counter holds.
- DATA: oe=1, data_out=latched data.
  - nxt=1: go to STOP.
  - ulpi_dir=1 (abort): retry+1, go to TXCMD.
- STOP (exactly one cycle): stp=1, data_out=0, oe=1 if owned, done=1, then IDLE. The write is committed once nxt is seen in DATA; dir in STOP does not cause a retry.
- Abort rule: dir rising in TXCMD or DATA counts one retry. If retry would exceed RETRY_LIMIT, go to ERR.
- NXT timeout: timeout counter reaching NXT_TIMEOUT goes to ERR.
- ERR (one cycle): oe=0, stp=0, done=1, err=1, then IDLE.
- Controller must drop en on the edge ending the done cycle. If en is still 1 in IDLE, a new write of the current inputs starts; this is intended.
- Latency with no stalls: en sampled at edge 0; TXCMD cycle 1 (nxt at once); DATA cycle 2; STOP/done cycle 3.

Optional Feature:
- Macro ULPI_EXT_ADDR_EN.
- Defined:
  - reg_write_addr is 8 bits.
  - If addr[7:6]==0 and addr!=8'h2F: immediate form, as above.
  - Otherwise: TXCMD carries {2'b10, 6'h2F}, then EXT_ADDR state drives the full 8-bit addr until nxt=1, then DATA.
  - EXT_ADDR follows the same abort/timeout rules, returning to TXCMD on abort.
- Undefined: 6-bit address, no EXT_ADDR state, immediate form only.

Decomposition:
- Package ulpi_pkg:
  - TXCMD codes: REGW 2'b10, REGR 2'b11.
  - EXT_ADDR_CODE 6'h2F.
  - State enum for this block.
- Sub-module ulpi_turnaround (dir_q register and bus-owned flag), shared with the read engine.

Test Plan:
- addr 6'h0A, data 8'h55, dir=0, nxt high cycle after each drive -> data_out 8'h8A, then 8'h55, then stp=1 with data 0; done on cycle 3; err=0.
- Same request, nxt withheld 3 cycles in TXCMD -> 8'h8A held 4 cycles; done 2 cycles after nxt.
- dir=1 for 2 cycles during DATA -> oe drops the same cycle, one turnaround cycle idle, TXCMD 8'h8A reissued; success.
- 5 aborts with RETRY_LIMIT=4 -> done=1, err=1, stp never asserted. Nxt held 0 for 255 owned cycles -> same error.
- rst_n low during DATA -> oe, stp, busy 0 immediately; after release, IDLE; en=1 restarts with TXCMD.
- ULPI_EXT_ADDR_EN, addr 8'h81, data 8'h01 -> 8'hAF, 8'h81, 8'h01, stp; addr 8'h2F also uses extended form.
